// File: rtl/cpu_pkg.sv
// Shared SM83 system definitions: timer register offsets, TAC clock select
// and timer sequencer state encodings.
package cpu_pkg;

   localparam logic [1:0] TIMER_DIV_OFS  = 2'd0;
   localparam logic [1:0] TIMER_TIMA_OFS = 2'd1;
   localparam logic [1:0] TIMER_TMA_OFS  = 2'd2;
   localparam logic [1:0] TIMER_TAC_OFS  = 2'd3;

   typedef enum logic [1:0] {
      TacClk4096   = 2'b00,
      TacClk262144 = 2'b01,
      TacClk65536  = 2'b10,
      TacClk16384  = 2'b11
   } tac_clk_sel_e;

   typedef enum logic {
      TimerIdle    = 1'b0,
      TimerPending = 1'b1
   } timer_state_e;

   // System-counter bit whose falling edge clocks TIMA for each TAC rate.
   function automatic logic [3:0] tac_tap_bit(input tac_clk_sel_e sel);
      case (sel)
         TacClk4096:   return 4'd9;
         TacClk262144: return 4'd3;
         TacClk65536:  return 4'd5;
         default:      return 4'd7;
      endcase
   endfunction

endpackage

// File: rtl/timer_tick_mux.sv
// Selects the system-counter tap feeding the TIMA edge detector and gates it
// with the TAC enable bit.
module timer_tick_mux
   import cpu_pkg::*;
(
   input  logic [15:0] sys_cnt,
   input  logic [2:0]  tac,
   output logic        tick_in
);

   always_comb begin
      tick_in = tac[2] & sys_cnt[tac_tap_bit(tac_clk_sel_e'(tac[1:0]))];
   end

endmodule

// File: rtl/timer_regs.sv
// SM83 timer block: DIV/TIMA/TMA/TAC bus responder, system divider and TIMA
// overflow/reload sequencer. Define TIMER_EDGE_GLITCH_EN for DMG write glitches.
module timer_regs
   import cpu_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hFF04,
   parameter logic [15:0] DIV_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  t_cycle,
   input  logic [15:0] bus_addr,
   input  logic        bus_enable,
   input  logic        bus_write,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        bus_selected,
   output logic        irq_timer
);

   logic [15:0]  sys_cnt, sys_cnt_next;
   logic [7:0]   tima, tima_next;
   logic [7:0]   tma;
   logic [2:0]   tac, tac_next;
   logic [1:0]   cnt, cnt_next;
   timer_state_e state, state_next;
   logic         irq_next;
   logic         tick_in, tick_q, tick_q_next, tick_fall;

   logic [15:0]  addr_ofs;
   logic [1:0]   reg_ofs;
   logic         commit, wr_div, wr_tima, wr_tma, wr_tac;

   assign addr_ofs     = bus_addr - BASE_ADDR;
   assign reg_ofs      = addr_ofs[1:0];
   assign bus_selected = bus_enable & (addr_ofs[15:2] == 14'd0);
   assign commit       = bus_selected & bus_write & (t_cycle == 2'd3);
   assign wr_div       = commit & (reg_ofs == TIMER_DIV_OFS);
   assign wr_tima      = commit & (reg_ofs == TIMER_TIMA_OFS);
   assign wr_tma       = commit & (reg_ofs == TIMER_TMA_OFS);
   assign wr_tac       = commit & (reg_ofs == TIMER_TAC_OFS);

   assign sys_cnt_next = wr_div ? 16'h0000 : sys_cnt + 16'd1;
   assign tac_next     = wr_tac ? bus_wdata[2:0] : tac;

   timer_tick_mux u_tick (
      .sys_cnt (sys_cnt),
      .tac     (tac),
      .tick_in (tick_in)
   );

`ifdef TIMER_EDGE_GLITCH_EN
   assign tick_q_next = tick_in;
`else
   // Preload the detector with the post-write tap so DIV/TAC writes never
   // look like a falling edge.
   logic tick_in_next;

   timer_tick_mux u_tick_next (
      .sys_cnt (sys_cnt_next),
      .tac     (tac_next),
      .tick_in (tick_in_next)
   );

   assign tick_q_next = (wr_div | wr_tac) ? tick_in_next : tick_in;
`endif

   assign tick_fall = tick_q & ~tick_in;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      tima_next  = tima;
      cnt_next   = cnt;
      irq_next   = 1'b0;
      case (state)
         TimerIdle: begin
            if (wr_tima) begin
               tima_next = bus_wdata;
            end else if (tick_fall) begin
               if (tima == 8'hFF) begin
                  tima_next  = 8'h00;
                  cnt_next   = 2'd3;
                  state_next = TimerPending;
               end else begin
                  tima_next = tima + 8'd1;
               end
            end
         end
         TimerPending: begin
            // Ticks are dropped here; the reload edge ignores TIMA writes.
            if (cnt == 2'd0) begin
               tima_next  = wr_tma ? bus_wdata : tma;
               irq_next   = 1'b1;
               state_next = TimerIdle;
            end else if (wr_tima) begin
               tima_next  = bus_wdata;
               state_next = TimerIdle;
            end else begin
               cnt_next = cnt - 2'd1;
            end
         end
         default: state_next = TimerIdle;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sys_cnt   <= DIV_RESET;
         tima      <= 8'h00;
         tma       <= 8'h00;
         tac       <= 3'b000;
         cnt       <= 2'd0;
         state     <= TimerIdle;
         irq_timer <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         sys_cnt   <= sys_cnt_next;
         tima      <= tima_next;
         tma       <= wr_tma ? bus_wdata : tma;
         tac       <= tac_next;
         cnt       <= cnt_next;
         state     <= state_next;
         irq_timer <= irq_next;
         tick_q    <= tick_q_next;
      end
   end

   always_comb begin
      bus_rdata = 8'hFF;
      if (bus_selected) begin
         case (reg_ofs)
            TIMER_DIV_OFS:  bus_rdata = sys_cnt[15:8];
            TIMER_TIMA_OFS: bus_rdata = tima;
            TIMER_TMA_OFS:  bus_rdata = tma;
            default:        bus_rdata = {5'b11111, tac};
         endcase
      end
   end

endmodule

// File: tb/tb_timer_regs.sv
// Self-checking bench for timer_regs: register access vector table plus
// hand-timed overflow, reload, glitch and reset sequences.
module tb_timer_regs;

   localparam logic [15:0] A_DIV  = 16'hFF04;
   localparam logic [15:0] A_TIMA = 16'hFF05;
   localparam logic [15:0] A_TMA  = 16'hFF06;
   localparam logic [15:0] A_TAC  = 16'hFF07;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  t_cycle = 2'd0;
   logic [15:0] bus_addr = 16'h0000;
   logic        bus_enable = 1'b0;
   logic        bus_write = 1'b0;
   logic [7:0]  bus_wdata = 8'h00;
   logic [7:0]  bus_rdata;
   logic        bus_selected;
   logic        irq_timer;

   int errors = 0;
   int checks = 0;
   int irq_cnt = 0;

   timer_regs dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .t_cycle      (t_cycle),
      .bus_addr     (bus_addr),
      .bus_enable   (bus_enable),
      .bus_write    (bus_write),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata),
      .bus_selected (bus_selected),
      .irq_timer    (irq_timer)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (irq_timer) irq_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        en;
      logic        wr;
      logic [1:0]  tc;
      logic [7:0]  exp_rd;
      logic        exp_sel;
   } vec_t;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic s);
      bus_addr   = a;
      bus_enable = 1'b1;
      bus_write  = 1'b0;
      t_cycle    = 2'd0;
      #1;
      d          = bus_rdata;
      s          = bus_selected;
      bus_enable = 1'b0;
   endtask

   task automatic chk_reg(input string name, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic       s;
      rd(a, d, s);
      check(name, d, exp);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus_addr   = a;
      bus_wdata  = d;
      bus_enable = 1'b1;
      bus_write  = 1'b1;
      t_cycle    = 2'd3;
      step();
      bus_enable = 1'b0;
      bus_write  = 1'b0;
      t_cycle    = 2'd0;
   endtask

   // Leaves the bench in the cycle where sys_cnt == 3 with TAC = 3'b101.
   task automatic setup_base(input logic [7:0] tima_v, input logic [7:0] tma_v);
      wr(A_DIV, 8'h00);
      wr(A_TAC, 8'h05);
      wr(A_TIMA, tima_v);
      wr(A_TMA, tma_v);
   endtask

   // Leaves the bench in the first Pending cycle (sys_cnt == 33).
   task automatic setup_overflow();
      setup_base(8'hFE, 8'h80);
      repeat (29) step();
      chk_reg("ovf_pre_ff", A_TIMA, 8'hFF);
      step();
   endtask

   vec_t vecs[10];

   initial begin
      logic [7:0] d;
      logic       s;
      int         n;

      vecs[0] = '{A_TMA,   8'hA5, 1'b1, 1'b1, 2'd3, 8'hA5, 1'b1};
      vecs[1] = '{A_TMA,   8'h12, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b1};
      vecs[2] = '{A_TMA,   8'h34, 1'b0, 1'b1, 2'd3, 8'hA5, 1'b0};
      vecs[3] = '{A_TIMA,  8'h3C, 1'b1, 1'b1, 2'd3, 8'h3C, 1'b1};
      vecs[4] = '{A_TAC,   8'h03, 1'b1, 1'b1, 2'd3, 8'hFB, 1'b1};
      vecs[5] = '{A_TAC,   8'hF8, 1'b1, 1'b1, 2'd3, 8'hF8, 1'b1};
      vecs[6] = '{16'hFF03, 8'h77, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b0};
      vecs[7] = '{16'hFF08, 8'h77, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b0};
      vecs[8] = '{A_TIMA,  8'h00, 1'b1, 1'b0, 2'd3, 8'h3C, 1'b1};
      vecs[9] = '{A_TMA,   8'h00, 1'b1, 1'b0, 2'd3, 8'hA5, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_reg("rst_tac", A_TAC, 8'hF8);
      chk_reg("rst_tima", A_TIMA, 8'h00);
      chk_reg("rst_tma", A_TMA, 8'h00);
      chk_reg("rst_div", A_DIV, 8'h00);
      check("rst_irq", irq_timer, 1'b0);
      rd(16'hFF03, d, s);
      check("unsel_ff03_sel", s, 1'b0);
      check("unsel_ff03_rd", d, 8'hFF);
      bus_addr = A_DIV;
      bus_enable = 1'b0;
      #1;
      check("noen_sel", bus_selected, 1'b0);
      check("noen_rd", bus_rdata, 8'hFF);
      reset_n = 1'b1;
      step();

      // Divider free run and DIV write
      wr(A_DIV, 8'h00);
      repeat (1023) step();
      chk_reg("div_1023", A_DIV, 8'h03);
      step();
      chk_reg("div_1024", A_DIV, 8'h04);
      wr(A_DIV, 8'h55);
      chk_reg("div_clear", A_DIV, 8'h00);
      repeat (255) step();
      chk_reg("div_255", A_DIV, 8'h00);
      step();
      chk_reg("div_256", A_DIV, 8'h01);

      // Register access table
      for (int i = 0; i < 10; i++) begin
         bus_addr   = vecs[i].addr;
         bus_wdata  = vecs[i].data;
         bus_enable = vecs[i].en;
         bus_write  = vecs[i].wr;
         t_cycle    = vecs[i].tc;
         #1;
         check($sformatf("vec%0d_sel", i), bus_selected, vecs[i].exp_sel);
         step();
         bus_enable = 1'b0;
         bus_write  = 1'b0;
         t_cycle    = 2'd0;
         chk_reg($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      end

      // Overflow and reload
      setup_base(8'hFE, 8'h80);
      repeat (13) step();
      chk_reg("ovf_fe_16", A_TIMA, 8'hFE);
      step();
      chk_reg("ovf_ff_17", A_TIMA, 8'hFF);
      repeat (15) step();
      chk_reg("ovf_ff_32", A_TIMA, 8'hFF);
      check("ovf_irq_pre", irq_timer, 1'b0);
      step();
      chk_reg("pend_0", A_TIMA, 8'h00);
      for (int i = 1; i < 4; i++) begin
         step();
         chk_reg($sformatf("pend_%0d", i), A_TIMA, 8'h00);
      end
      n = irq_cnt;
      step();
      chk_reg("reload_tima", A_TIMA, 8'h80);
      check("reload_irq", irq_timer, 1'b1);
      step();
      check("reload_irq_drop", irq_timer, 1'b0);
      chk_reg("reload_hold", A_TIMA, 8'h80);
      check("reload_irq_once", 8'(irq_cnt - n), 8'd1);

      // TIMA write in the 2nd Pending clock cancels the reload
      setup_overflow();
      step();
      wr(A_TIMA, 8'h10);
      chk_reg("cancel_tima", A_TIMA, 8'h10);
      n = irq_cnt;
      repeat (5) step();
      chk_reg("cancel_hold", A_TIMA, 8'h10);
      check("cancel_no_irq", 8'(irq_cnt - n), 8'd0);

      // TMA write on the reload edge feeds TIMA directly
      setup_overflow();
      n = irq_cnt;
      repeat (3) step();
      wr(A_TMA, 8'h33);
      chk_reg("tma_fwd_tima", A_TIMA, 8'h33);
      chk_reg("tma_fwd_tma", A_TMA, 8'h33);
      check("tma_fwd_irq", irq_timer, 1'b1);
      step();
      check("tma_fwd_irq_once", 8'(irq_cnt - n), 8'd1);

      // TIMA write on the reload edge is ignored
      setup_overflow();
      repeat (3) step();
      wr(A_TIMA, 8'h77);
      chk_reg("reload_wr_ign", A_TIMA, 8'h80);
      check("reload_wr_irq", irq_timer, 1'b1);

      // Write beats a tick on the same edge
      setup_base(8'h20, 8'h80);
      repeat (13) step();
      wr(A_TIMA, 8'h50);
      chk_reg("wr_vs_tick", A_TIMA, 8'h50);
      repeat (16) step();
      chk_reg("tick_after_wr", A_TIMA, 8'h51);

      // Disabling TAC stops ticks
      wr(A_TAC, 8'h01);
      repeat (16) step();
      chk_reg("tac_off_tima", A_TIMA, 8'h51);
      chk_reg("tac_off_rd", A_TAC, 8'hF9);

      // DIV write while the selected tap is high
      wr(A_DIV, 8'h00);
      wr(A_TAC, 8'h04);
      wr(A_TIMA, 8'h40);
      repeat (600) step();
      chk_reg("glitch_pre", A_TIMA, 8'h40);
      wr(A_DIV, 8'h00);
      step();
`ifdef TIMER_EDGE_GLITCH_EN
      chk_reg("glitch_div", A_TIMA, 8'h41);
`else
      chk_reg("glitch_div", A_TIMA, 8'h40);
`endif

      // Reset mid-Pending
      setup_overflow();
      step();
      reset_n = 1'b0;
      #1;
      chk_reg("midrst_tima", A_TIMA, 8'h00);
      chk_reg("midrst_tma", A_TMA, 8'h00);
      chk_reg("midrst_tac", A_TAC, 8'hF8);
      chk_reg("midrst_div", A_DIV, 8'h00);
      check("midrst_irq", irq_timer, 1'b0);
      n = irq_cnt;
      repeat (3) step();
      reset_n = 1'b1;
      repeat (10) step();
      check("midrst_no_irq", 8'(irq_cnt - n), 8'd0);
      chk_reg("midrst_tima_after", A_TIMA, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_regs.md
Name: timer_regs

Overview:
- Bus responder for the SM83 system bus: answers CPU accesses to the timer registers DIV/TIMA/TMA/TAC at 0xFF04-0xFF07.
- Runs the 16-bit system divider and the TIMA overflow/reload sequencer.
- Raises a 1-clock timer interrupt request toward the interrupt controller.
- Sits beside the CPU on the same 4 MHz clk; uses the CPU's T-cycle phase to commit writes.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC follow at +1/+2/+3.
- DIV_RESET, 16'h0000, system counter value after reset.

Ports:
- clk  in  1  system clock (4 MHz), all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- t_cycle  in  2  CPU T-cycle phase (0..3); writes commit when t_cycle==3.
- bus_addr  in  16  CPU mem_addr.
- bus_enable  in  1  CPU mem_enable.
- bus_write  in  1  CPU mem_write.
- bus_wdata  in  8  CPU mem_data_out.
- bus_rdata  out  8  read data, combinational from register state.
- bus_selected  out  1  high when bus_enable and bus_addr in BASE_ADDR..BASE_ADDR+3.
- irq_timer  out  1  registered 1-clk interrupt pulse.

Behaviour:
- Reset: sys_cnt=DIV_RESET, TIMA=0, TMA=0, TAC=0, FSM=Idle, irq_timer=0. bus_rdata follows the decode rules below and is 8'hFF when not selected.
- Write commit: posedge with t_cycle==3, bus_enable, bus_write, address hit. No other cycle changes registers from the bus.
- sys_cnt: 16-bit, increments every clk, wraps 16'hFFFF->0. A DIV write (any data) forces 0 on that edge instead of incrementing.
- Reads:
  - DIV=sys_cnt[15:8]
  - TIMA, TMA as stored
  - TAC={5'b11111, TAC[2:0]}
  - not selected -> 8'hFF
- Tick source: sel = TAC[1:0] -> sys_cnt bit 9/3/5/7 for 00/01/10/11. tick_in = TAC[2] & sys_cnt[sel].
- TIMA increments on the falling edge of tick_in, detected via a registered copy of tick_in.
- FSM Idle: on a tick with TIMA==8'hFF, TIMA<=0 and go to Pending with cnt=3.
- FSM Pending: 4 clocks, TIMA reads 0.
  - cnt decrements each clock.
  - A TIMA write during Pending: TIMA<=wdata, FSM->Idle, no reload, no irq.
  - On the edge where cnt==0: TIMA<=TMA (or bus_wdata if TMA is written that same edge), irq_timer<=1 for exactly one clock, FSM->Idle.
- Reload edge: a TIMA write on the reload edge is ignored.
- Ticks during Pending are dropped.
- Simultaneous events in Idle: a TIMA write and a tick on the same edge -> the write wins.
- TAC written with TAC[2]=0: ticks stop on the next edge. An in-flight Pending still completes.
- reset_n asserted mid-Pending: sequence aborted, irq never pulses.

Optional Feature:
- Macro: TIMER_EDGE_GLITCH_EN.
- Defined: a DIV or TAC write that causes tick_in to fall produces a TIMA increment, as on DMG hardware. Example: sys_cnt[9]=1 with TAC=3'b100, then write DIV -> TIMA+1.
- Undefined: the falling-edge detector register is reloaded with the new tick_in on DIV/TAC writes, so these writes never increment TIMA.

Decomposition:
- Shared package cpu_pkg:
  - timer address constants (DIV/TIMA/TMA/TAC offsets)
  - enum tac_clk_sel_e {TacClk4096, TacClk262144, TacClk65536, TacClk16384}
  - enum timer_state_e {TimerIdle, TimerPending}
- One sub-module timer_tick_mux: sys_cnt + TAC in, tick_in out, combinational bit select.
- Edge detect and FSM stay in timer_regs.

Test Plan:
- Reset, then read 0xFF07 -> 8'hF8. Read 0xFF03 -> bus_selected=0, rdata=8'hFF.
- Free run 1024 clks -> DIV reads 8'h04. Write DIV=8'h55 -> DIV reads 8'h00 next cycle and sys_cnt restarts at 0.
- TAC=3'b101, TIMA=8'hFE, TMA=8'h80 -> TIMA 8'hFF after 16 clks, then 8'h00 for 4 clks. TIMA=8'h80 and irq_timer high exactly 1 clk.
- Same overflow, TIMA write of 8'h10 in the 2nd Pending clk -> TIMA=8'h10, irq_timer never asserts.
- Same overflow, TMA write of 8'h33 on the reload edge -> TIMA=8'h33, irq pulses once.
- TAC=3'b100, run until sys_cnt[9]=1, write DIV -> TIMA+1 with TIMER_EDGE_GLITCH_EN, unchanged without. Assert reset_n low mid-Pending -> all registers 0, irq_timer 0.
